fp_mul_norm_round: RTL

FP_MUL_NORM_ROUND -- requirements
Module: fp_mul_norm_round

---
 rtl/fp_mul_norm_round.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fp_mul_norm_round.sv
// Two-stage FP32 multiplier back end: S1 normalizes the raw 48-bit product, S2 rounds and packs.
// Define FP_MUL_RNE_EN for round-to-nearest-even; the default build rounds half-up.
module fp_mul_norm_round #(
  localparam int unsigned EXP_W  = 9,
  localparam int unsigned MANT_W = 48,
  localparam int unsigned RES_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp_sum,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_result,
  output logic              out_ovf,
  output logic              out_unf
);

  localparam int unsigned E_W    = 10;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned BIAS   = 127;
  localparam int unsigned EMAX   = 255;

  // Stage 1 registers
  logic              r_s1_valid;
  logic              r_sign;
  logic [E_W-1:0]    r_e;
  logic [FRAC_W-1:0] r_frac;
  logic              r_guard;
  logic              r_zero;
`ifdef FP_MUL_RNE_EN
  logic              r_sticky;
  logic              w_sticky;
`endif

  // Stage 2 (output) registers
  logic              r_out_valid;
  logic [RES_W-1:0]  r_out_result;
  logic              r_out_ovf;
  logic              r_out_unf;

  logic              w_s1_adv;
  logic              w_s2_adv;
  logic              w_norm;
  logic [FRAC_W-1:0] w_frac;
  logic              w_guard;
  logic [E_W-1:0]    w_e;
  logic              w_round_up;
  logic [FRAC_W:0]   w_frac_r;
  logic [E_W-1:0]    w_e_r;
  logic [RES_W-1:0]  w_result;
  logic              w_ovf;
  logic              w_unf;

  assign w_s2_adv = ~r_out_valid | out_ready;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;
  assign in_ready = w_s1_adv;

  // Normalize: the product of two 1.x significands has its leading one at bit 47 or 46
  assign w_norm  = in_mant[MANT_W-1];
  assign w_frac  = w_norm ? in_mant[46:24] : in_mant[45:23];
  assign w_guard = w_norm ? in_mant[23] : in_mant[22];
  assign w_e     = E_W'(in_exp_sum) - E_W'(BIAS) + E_W'(w_norm);
`ifdef FP_MUL_RNE_EN
  assign w_sticky = w_norm ? (|in_mant[22:0]) : (|in_mant[21:0]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_sign     <= 1'b0;
      r_e        <= '0;
      r_frac     <= '0;
      r_guard    <= 1'b0;
      r_zero     <= 1'b0;
`ifdef FP_MUL_RNE_EN
      r_sticky   <= 1'b0;
`endif
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_sign   <= in_sign;
        r_e      <= w_e;
        r_frac   <= w_frac;
        r_guard  <= w_guard;
        r_zero   <= (in_mant == '0);
`ifdef FP_MUL_RNE_EN
        r_sticky <= w_sticky;
`endif
      end
    end
  end

`ifdef FP_MUL_RNE_EN
  assign w_round_up = r_guard & (r_sticky | r_frac[0]);
`else
  assign w_round_up = r_guard;
`endif

  // A carry out of the fraction leaves it zero and bumps the exponent
  assign w_frac_r = {1'b0, r_frac} + (FRAC_W+1)'(w_round_up);
  assign w_e_r    = r_e + E_W'(w_frac_r[FRAC_W]);

  // Round and pack: zero beats overflow beats underflow
  always_comb begin
    w_result = {r_sign, w_e_r[7:0], w_frac_r[FRAC_W-1:0]};
    w_ovf    = 1'b0;
    w_unf    = 1'b0;
    if (r_zero) begin
      w_result = {r_sign, 31'b0};
    end else if (!w_e_r[E_W-1] && (w_e_r >= E_W'(EMAX))) begin
      w_result = {r_sign, 8'hFF, 23'b0};
      w_ovf    = 1'b1;
    end else if (w_e_r[E_W-1] || (w_e_r == '0)) begin
      w_result = {r_sign, 31'b0};
      w_unf    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_ovf    <= 1'b0;
      r_out_unf    <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_result <= w_result;
        r_out_ovf    <= w_ovf;
        r_out_unf    <= w_unf;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_ovf    = r_out_ovf;
  assign out_unf    = r_out_unf;

endmodule
